// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 slave: sync, bit counting, rx strobe, tx serialiser
// Optional overrun tracking enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    input  logic [N-1:0] tx_data,
    output logic         tx_take,
    output logic [N-1:0] rx_data,
    output logic         rx_load,
    output logic         frame_err,
    input  logic         rx_ack,
    output logic         rx_ovr
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic          sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic          cs_meta_q, cs_sync_q;
    logic          mosi_meta_q, mosi_sync_q;
    logic          sclk_rise, sclk_fall;

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]  rx_shift_q, rx_shift_d;
    logic [N-1:0]  tx_shift_q, tx_shift_d;
    logic [N-1:0]  rx_data_q, rx_data_d;
    logic          rx_load_q, rx_load_d;
    logic          tx_take_q, tx_take_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs_n;
            cs_sync_q   <= cs_meta_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_load_q   <= 1'b0;
            tx_take_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_load_q   <= rx_load_d;
            tx_take_q   <= tx_take_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_load_d   = 1'b0;
        tx_take_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cs_sync_q) begin
                    tx_shift_d = tx_data;
                    tx_take_d  = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Chip-select release takes priority over a coincident final edge.
                if (cs_sync_q) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[N-2:0], mosi_sync_q};
                    if (bit_cnt_q == CW'(N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (sclk_fall && (bit_cnt_q != '0)) begin
                    // The fall right after a reload is skipped so the new MSB survives.
                    tx_shift_d = {tx_shift_q[N-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                rx_load_d = 1'b1;
                rx_data_d = rx_shift_q;
                if (!cs_sync_q) begin
                    tx_shift_d = tx_data;
                    tx_take_d  = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign miso      = (!cs_sync_q && (state_q != ST_IDLE)) ? tx_shift_q[N-1] : 1'b0;
    assign rx_data   = rx_data_q;
    assign rx_load   = rx_load_q;
    assign tx_take   = tx_take_q;
    assign frame_err = frame_err_q;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic pending_q, pending_d;
    logic rx_ovr_q, rx_ovr_d;

    // A new word always re-arms pending; a coincident ack only retires the old one.
    assign pending_d = rx_load_q ? 1'b1 : (rx_ack ? 1'b0 : pending_q);
    assign rx_ovr_d  = rx_ovr_q | (rx_load_q & pending_q & ~rx_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rx_ovr_q  <= rx_ovr_d;
        end
    end

    assign rx_ovr = rx_ovr_q;
`else
    logic unused_rx_ack;
    assign unused_rx_ack = rx_ack;
    assign rx_ovr        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - scoreboard bench for spi_slave_ctrl (N=8)
module tb_spi_slave_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       sclk, cs_n, mosi, miso;
    logic [7:0] tx_data;
    logic       tx_take;
    logic [7:0] rx_data;
    logic       rx_load, frame_err, rx_ack, rx_ovr;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    spi_slave_ctrl #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_take   (tx_take),
        .rx_data   (rx_data),
        .rx_load   (rx_load),
        .frame_err (frame_err),
        .rx_ack    (rx_ack),
        .rx_ovr    (rx_ovr)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_rise_cyc = 0;
    int         prev_load_cyc = 0;
    int         load_gap = 0;
    int         load_cnt = 0;
    int         take_cnt = 0;
    int         ferr_cnt = 0;
    logic       ack_mode;
    logic [7:0] sb_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_rx;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] mi;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        rx_ack = ack_mode && rx_load;
        if (tx_take) begin
            take_cnt++;
            if (tx_q.size() > 0) tx_data = tx_q.pop_front();
        end
        if (frame_err) ferr_cnt++;
        if (rx_load) begin
            load_cnt++;
            load_gap      = cyc - prev_load_cyc;
            prev_load_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("rx_unexpected", sb_q.size(), 1);
            end else begin
                exp_rx  = sb_q.pop_front();
                last_rx = exp_rx;
                chk("rx_data", rx_data, exp_rx);
            end
            chk("rx_latency", cyc - last_rise_cyc, 4);
        end
    end

    // MSB-first mode-0 master; end_frame releases cs_n one clk after the last rise.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int hp,
                            input logic end_frame, output logic [7:0] mo_mi);
        mo_mi = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            mosi = mo[7-b];
            repeat (hp) @(negedge clk);
            mo_mi[7-b] = miso;
            sclk = 1'b1;
            if (b == nbits - 1) last_rise_cyc = cyc;
            if (end_frame && (b == nbits - 1)) begin
                @(negedge clk);
                cs_n = 1'b1;
                repeat (hp - 1) @(negedge clk);
            end else begin
                repeat (hp) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic clear_counts();
        load_cnt = 0;
        take_cnt = 0;
        ferr_cnt = 0;
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; rx_ack = 1'b0; ack_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {miso, tx_take, rx_load, frame_err, rx_ovr, rx_data}, 0);
        reset = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);

        // single word 0xA5 / tx 0x3C
        tx_data = 8'h3C;
        start_frame();
        sb_q.push_back(8'hA5);
        spi_xfer(8'hA5, 8, 8, 1'b1, mi);
        chk("t1_miso", mi, 8'h3C);
        repeat (10) @(negedge clk);
        chk("t1_loads", load_cnt, 1);
        chk("t1_takes", take_cnt, 1);
        chk("t1_ferr", ferr_cnt, 0);

        // back-to-back words with tx_data updated after the first take
        clear_counts();
        tx_data = 8'h55;
        tx_q.push_back(8'h81);
        start_frame();
        sb_q.push_back(8'h01);
        spi_xfer(8'h01, 8, 8, 1'b0, mi);
        chk("t2_miso0", mi, 8'h55);
        sb_q.push_back(8'hFE);
        spi_xfer(8'hFE, 8, 8, 1'b1, mi);
        chk("t2_miso1", mi, 8'h81);
        repeat (10) @(negedge clk);
        chk("t2_loads", load_cnt, 2);
        chk("t2_takes", take_cnt, 2);

        // cs_n released after 5 bits
        clear_counts();
        start_frame();
        spi_xfer(8'hB7, 5, 8, 1'b0, mi);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3_ferr", ferr_cnt, 1);
        chk("t3_loads", load_cnt, 0);
        chk("t3_rx_hold", rx_data, last_rx);
        clear_counts();
        tx_data = 8'h96;
        start_frame();
        sb_q.push_back(8'h5A);
        spi_xfer(8'h5A, 8, 8, 1'b1, mi);
        chk("t3_miso", mi, 8'h96);
        repeat (10) @(negedge clk);
        chk("t3_loads2", load_cnt, 1);
        chk("t3_ferr2", ferr_cnt, 0);

        // reset mid-word
        tx_data = 8'h0F;
        start_frame();
        spi_xfer(8'hE0, 3, 8, 1'b0, mi);
        reset = 1'b0;
        @(negedge clk);
        chk("t4_in_reset", {miso, tx_take, rx_load, frame_err, rx_ovr, rx_data}, 0);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_counts();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        start_frame();
        sb_q.push_back(8'hC3);
        spi_xfer(8'hC3, 8, 8, 1'b1, mi);
        repeat (10) @(negedge clk);
        chk("t4_loads", load_cnt, 1);
        chk("t4_ferr", ferr_cnt, 0);

        // overrun: no ack, then ack on every word
        pulse_reset();
        ack_mode = 1'b0;
        start_frame();
        sb_q.push_back(8'h11);
        spi_xfer(8'h11, 8, 8, 1'b0, mi);
        sb_q.push_back(8'h22);
        spi_xfer(8'h22, 8, 8, 1'b1, mi);
        repeat (10) @(negedge clk);
        chk("t5_ovr_noack", rx_ovr, OVR_EN);
        repeat (20) @(negedge clk);
        chk("t5_ovr_held", rx_ovr, OVR_EN);
        pulse_reset();
        ack_mode = 1'b1;
        start_frame();
        sb_q.push_back(8'h33);
        spi_xfer(8'h33, 8, 8, 1'b0, mi);
        sb_q.push_back(8'h44);
        spi_xfer(8'h44, 8, 8, 1'b1, mi);
        repeat (10) @(negedge clk);
        chk("t5_ovr_ack", rx_ovr, 0);

        // sclk at clk/4, 0xFF then 0x00
        clear_counts();
        start_frame();
        sb_q.push_back(8'hFF);
        spi_xfer(8'hFF, 8, 2, 1'b0, mi);
        sb_q.push_back(8'h00);
        spi_xfer(8'h00, 8, 2, 1'b1, mi);
        repeat (10) @(negedge clk);
        chk("t6_loads", load_cnt, 2);
        chk("t6_gap", load_gap, 32);
        chk("t6_takes", take_cnt, 2);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI mode-0 slave controller for the SPI task FPGA design. It samples the external SCLK, CS_N and MOSI lines, counts bits and sequences its own shift registers. Once per N-bit word it produces the load strobe and data for the downstream registerN holding register. It also serialises a parallel transmit word onto MISO and supports back-to-back words within one CS_N assertion.

Parameters:
N, 8, word length in bits; legal range N >= 2.
CW, $clog2(N), bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock; must run at least 4x the SCLK frequency.
reset  input  1  asynchronous, active-low reset; all state cleared while 0.
sclk  input  1  SPI clock from master; asynchronous to clk.
cs_n  input  1  SPI chip select, active-low; asynchronous to clk.
mosi  input  1  master-out data; asynchronous to clk.
miso  output  1  slave-out data.
tx_data  input  N  word to transmit; sampled at each word start.
tx_take  output  1  one-cycle pulse when tx_data is captured.
rx_data  output  N  received word; valid while rx_load=1.
rx_load  output  1  one-cycle strobe; drives the holding register's load input.
frame_err  output  1  one-cycle pulse when CS_N rises mid-word.
rx_ack  input  1  consumer acknowledge; used only with the optional feature.
rx_ovr  output  1  sticky overrun flag; used only with the optional feature.

Behaviour:
- Synchronisers: sclk, cs_n and mosi each pass through a 2-flop synchroniser. Reset values are sclk=0, cs_n=1, mosi=0.
- Edge detection: registered previous synchronised sclk gives sclk_rise and sclk_fall, each one clk cycle wide.
- Reset values: miso=0, tx_take=0, rx_load=0, frame_err=0, rx_ovr=0, rx_data=0, bit_cnt=0, both shift registers=0, state=IDLE.
- miso = tx_shift[N-1] when synchronised cs_n=0 and state != IDLE; otherwise miso=0. No tri-state.
- FSM state IDLE:
  - On synchronised cs_n=0: tx_shift<=tx_data, tx_take=1 for one cycle, bit_cnt<=0, go to SHIFT.
- FSM state SHIFT:
  - On sclk_rise: rx_shift<={rx_shift[N-2:0], mosi_s} and bit_cnt<=bit_cnt+1.
  - If bit_cnt==N-1 on that rise, go to DONE.
  - On sclk_fall with bit_cnt!=0: tx_shift<={tx_shift[N-2:0],1'b0}.
  - sclk_fall with bit_cnt==0 is ignored. This preserves the MSB after a reload.
  - Synchronised cs_n=1: frame_err=1 for one cycle, go to IDLE. No rx_load, rx_shift discarded.
- FSM state DONE (exactly one cycle):
  - rx_load=1 and rx_data=rx_shift.
  - If cs_n still 0: tx_shift<=tx_data, tx_take=1, bit_cnt<=0, go to SHIFT.
  - Else go to IDLE.
- Latency: rx_load asserts 4 clk cycles after the Nth SCLK rising edge at the pin (2 sync + 1 edge + 1 FSM).
- Bit order: MSB first in both directions.
- rx_data holds its last value between strobes.
- Simultaneous cs_n rise and Nth sclk_rise in the same cycle: cs_n wins, giving frame_err and no rx_load.
- Reset asserted mid-word: immediate return to reset values. Partial word lost, no strobe.
- bit_cnt wraps only through the DONE reload. It never exceeds N-1.

Optional Feature:
Macro SPI_SLAVE_OVERRUN_EN.
- Defined:
  - An internal pending flag sets on rx_load and clears on rx_ack=1.
  - If rx_load occurs while pending is still set, rx_ovr sets and stays set until reset.
  - rx_ack and rx_load in the same cycle: the ack clears the old word, the new word sets pending, and no overrun is flagged.
- Not defined: rx_ack is ignored, pending logic is absent, and rx_ovr is tied to 0.

Test Plan:
- N=8, cs_n low, master sends 0xA5, tx_data=0x3C -> rx_load pulses once with rx_data=0xA5; master samples MISO bits 0,0,1,1,1,1,0,0; tx_take pulses once at CS_N fall.
- Two words 0x01, 0xFE in one CS_N assertion, tx_data changed to 0x81 after the first tx_take -> rx_load twice with 0x01 then 0xFE; second MISO word reads 0x81, MSB present before its first rising edge.
- CS_N raised after 5 SCLK rises -> frame_err single pulse, no rx_load, rx_data unchanged; next full frame 0x5A received correctly.
- reset pulled low after 3 bits, released, then full frame 0xC3 -> all outputs 0 during reset; then rx_data=0xC3 with exactly one rx_load.
- With SPI_SLAVE_OVERRUN_EN: two words without rx_ack -> rx_ovr=1 after the second rx_load and held; with rx_ack after each word, rx_ovr stays 0. Without the macro, rx_ovr stays 0 in both cases.
- SCLK at exactly clk/4 with pattern 0xFF then 0x00 -> no missed or duplicated bits; rx_load spacing equals 8 SCLK periods.
